// File: rtl/ifmap_feeder_pkg.sv
// rtl/ifmap_feeder_pkg.sv - shared types, defaults and frame sizing for the ifmap feeder
package feeder_pkg;

  localparam int DATA_W        = 64;
  localparam int ROWS          = 64;
  localparam int WORDS_PER_ROW = 256;
  localparam int FIFO_DEPTH    = 16;
  localparam int CNT_W         = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_e;

  function automatic logic [CNT_W-1:0] frame_words(
    input logic [1:0] cfg_ci,
    input int         rows = ROWS,
    input int         wpr  = WORDS_PER_ROW
  );
    logic [31:0] n;
    n = rows * wpr * (int'(cfg_ci) + 1);
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ifmap_feeder_if.sv
// rtl/ifmap_feeder_if.sv - host word stream and controller read_I/Idata bundle
interface ifmap_feeder_if #(
  parameter int DATA_W = 64
);
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              read_I;
  logic [DATA_W-1:0] Idata;
  logic              i_valid;

  modport master (
    output host_valid, host_data, read_I,
    input  host_ready, Idata, i_valid
  );

  modport slave (
    input  host_valid, host_data, read_I,
    output host_ready, Idata, i_valid
  );
endinterface

// File: rtl/ifmap_feeder_sync_fifo.sv
// rtl/ifmap_feeder_sync_fifo.sv - single-clock FIFO with registered read data
module sync_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB tells full from empty once the indices wrap.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rdata_q <= mem_q[rptr_q[AW-1:0]];
        rptr_q  <= rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ifmap_feeder.sv
// rtl/ifmap_feeder.sv - buffers host feature words and answers read_I with one registered word per request
module ifmap_feeder #(
  parameter int DATA_W        = feeder_pkg::DATA_W,
  parameter int ROWS          = feeder_pkg::ROWS,
  parameter int WORDS_PER_ROW = feeder_pkg::WORDS_PER_ROW,
  parameter int FIFO_DEPTH    = feeder_pkg::FIFO_DEPTH,
  parameter int CNT_W         = feeder_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_conv,
  input  logic [1:0]           cfg_ci,
  ifmap_feeder_if.slave        bus,
  output logic                 frame_done,
  output logic                 underflow,
  output logic                 busy
);
  localparam logic [1:0] ST_IDLE   = feeder_pkg::IDLE;
  localparam logic [1:0] ST_STREAM = feeder_pkg::STREAM;
  localparam logic [1:0] ST_DONE   = feeder_pkg::DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             underflow_q, underflow_d;
  logic             i_valid_q;
  logic             streaming;
  logic             host_ready;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign streaming  = (state_q == ST_STREAM);
  assign host_ready = streaming && !fifo_full && (in_cnt_q < total_q);
  assign push       = bus.host_valid && host_ready;
  assign pop        = bus.read_I && streaming && !fifo_empty;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.host_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    underflow_d = underflow_q | (bus.read_I && !pop);
    case (state_q)
      ST_IDLE: begin
        if (start_conv) begin
          state_d   = ST_STREAM;
          total_d   = CNT_W'(feeder_pkg::frame_words(cfg_ci, ROWS, WORDS_PER_ROW));
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      // out_cnt lands on total in the i_valid cycle of the last word, so
      // leaving here one cycle later puts frame_done right after that pulse.
      ST_STREAM: begin
        if (out_cnt_q == total_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (push) begin
      in_cnt_d = in_cnt_q + 1'b1;
    end
    if (pop) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      underflow_q <= 1'b0;
      i_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      underflow_q <= underflow_d;
      i_valid_q   <= pop;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.Idata      = fifo_rdata;
  assign bus.i_valid    = i_valid_q;
  assign frame_done     = (state_q == ST_DONE);
  assign underflow      = underflow_q;
  assign busy           = streaming;

endmodule

// File: tb/tb_ifmap_feeder.sv
// tb/tb_ifmap_feeder.sv - randomized self-checking bench for ifmap_feeder
module tb_ifmap_feeder;
  localparam int DW  = 64;
  localparam int RW  = 2;
  localparam int WPR = 4;
  localparam int FD  = 16;
  localparam int CW  = 17;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_conv = 1'b0;
  logic [1:0] cfg_ci = 2'd0;
  logic       frame_done;
  logic       underflow;
  logic       busy;

  always #5 clk = ~clk;

  ifmap_feeder_if #(.DATA_W(DW)) bus ();

  ifmap_feeder #(
    .DATA_W        (DW),
    .ROWS          (RW),
    .WORDS_PER_ROW (WPR),
    .FIFO_DEPTH    (FD),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_conv (start_conv),
    .cfg_ci     (cfg_ci),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .underflow  (underflow),
    .busy       (busy)
  );

  // Frame-level model: a word queue plus a few counters and phase flags.
  bit          m_active;
  bit          m_done;
  int          m_total;
  int          m_in;
  int          m_out;
  logic [63:0] m_q[$];
  bit          m_unf;
  bit          m_iv;
  logic [63:0] m_idata;
  int          pushes;

  logic [63:0] seen[$];
  int          done_seen;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound(input string name, input int n);
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL %s: cycle budget %0d exhausted, required completion", name, LIMIT);
    end
  endtask

  function automatic bit frame_open();
    return m_active || m_done;
  endfunction

  task automatic step(input bit hv, input logic [63:0] hd, input bit rd, input bit st, input logic [1:0] ci);
    bit exp_ready;
    bit push;
    bit pop;
    bit fin;
    exp_ready = m_active && (m_q.size() < FD) && (m_in < m_total);
    chk("host_ready", 64'(bus.host_ready), 64'(exp_ready));
    chk("i_valid",    64'(bus.i_valid),    64'(m_iv));
    chk("Idata",      bus.Idata,           m_idata);
    chk("frame_done", 64'(frame_done),     64'(m_done));
    chk("underflow",  64'(underflow),      64'(m_unf));
    chk("busy",       64'(busy),           64'(m_active));
    if (bus.i_valid) seen.push_back(bus.Idata);
    if (frame_done) done_seen++;

    bus.host_valid = hv;
    bus.host_data  = hd;
    bus.read_I     = rd;
    start_conv     = st;
    cfg_ci         = ci;

    push = hv && exp_ready;
    pop  = rd && m_active && (m_q.size() > 0);
    fin  = m_active && (m_out == m_total);
    if (rd && !pop) m_unf = 1'b1;
    m_iv = pop;
    if (pop) begin
      m_idata = m_q.pop_front();
      m_out++;
    end
    if (push) begin
      m_q.push_back(hd);
      m_in++;
      pushes++;
    end
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_total  = RW * WPR * (int'(ci) + 1);
        m_in     = 0;
        m_out    = 0;
      end
    end else if (fin) begin
      m_active = 1'b0;
      m_done   = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.read_I     = 1'b0;
    start_conv     = 1'b0;
    #1;
    chk("rst_host_ready", 64'(bus.host_ready), 64'd0);
    chk("rst_i_valid",    64'(bus.i_valid),    64'd0);
    chk("rst_Idata",      bus.Idata,           64'd0);
    chk("rst_frame_done", 64'(frame_done),     64'd0);
    chk("rst_underflow",  64'(underflow),      64'd0);
    chk("rst_busy",       64'(busy),           64'd0);
    m_active = 1'b0;
    m_done   = 1'b0;
    m_total  = 0;
    m_in     = 0;
    m_out    = 0;
    m_q.delete();
    m_unf    = 1'b0;
    m_iv     = 1'b0;
    m_idata  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          p0;
    logic [63:0] word;
    logic [1:0]  rci;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.read_I     = 1'b0;
    checks = 0;
    errors = 0;
    pushes = 0;
    done_seen = 0;

    @(negedge clk);
    do_reset();

    // Idle: host offers words without start_conv.
    repeat (5) step(1'b1, 64'hAA, 1'b0, 1'b0, 2'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Frame of 16 words, reads whenever buffered data exists.
    seen.delete();
    done_seen = 0;
    step(1'b0, 64'd0, 1'b0, 1'b1, 2'd1);
    word = 0;
    n = 0;
    while (frame_open() && n < LIMIT) begin
      p0 = pushes;
      step(1'b1, word, (m_q.size() > 0), 1'b0, 2'd0);
      if (pushes != p0) word++;
      n++;
    end
    bound("t2_frame", n);
    chk("t2_count", 64'(seen.size()), 64'd16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("t2_word", seen[i], 64'(i));
    chk("t2_done_pulses", 64'(done_seen), 64'd1);
    chk("t2_busy_after", 64'(busy), 64'd0);

    // Fill to depth with no reads, then drain.
    seen.delete();
    step(1'b0, 64'd0, 1'b0, 1'b1, 2'd1);
    word = 0;
    p0 = pushes;
    for (int i = 0; i < 20; i++) begin
      int pb;
      pb = pushes;
      step(1'b1, word, 1'b0, 1'b0, 2'd0);
      if (pushes != pb) word++;
    end
    chk("t3_accepted", 64'(pushes - p0), 64'd16);
    chk("t3_ready_low", 64'(bus.host_ready), 64'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 2'd0);
    n = 0;
    while (frame_open() && n < LIMIT) begin
      step(1'b0, 64'd0, 1'b0, 1'b0, 2'd0);
      n++;
    end
    bound("t3_frame", n);
    chk("t3_count", 64'(seen.size()), 64'd16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("t3_word", seen[i], 64'(i));

    // Read on an empty FIFO inside a frame, then finish it randomly.
    seen.delete();
    done_seen = 0;
    step(1'b0, 64'd0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 2'd0);
    n = 0;
    while (frame_open() && n < LIMIT) begin
      step(($urandom_range(0, 1) == 1), {$urandom(), $urandom()},
           (m_q.size() > 0) && ($urandom_range(0, 1) == 1), 1'b0, 2'd0);
      n++;
    end
    bound("t4_frame", n);
    chk("t4_count", 64'(seen.size()), 64'd8);
    chk("t4_done_pulses", 64'(done_seen), 64'd1);
    chk("t4_underflow_sticky", 64'(underflow), 64'd1);

    // Push and pop together at occupancy one, two frames of 32 words.
    do_reset();
    seen.delete();
    for (int f = 0; f < 2; f++) begin
      step(1'b0, 64'd0, 1'b0, 1'b1, 2'd3);
      n = 0;
      while (frame_open() && n < LIMIT) begin
        step(1'b1, {$urandom(), $urandom()}, (m_q.size() > 0), 1'b0, 2'd0);
        n++;
      end
      bound("t5_frame", n);
    end
    chk("t5_count", 64'(seen.size()), 64'd64);
    chk("t5_underflow", 64'(underflow), 64'd0);

    // Random traffic with stray start_conv pulses during the frame.
    do_reset();
    seen.delete();
    rci = 2'($urandom_range(0, 3));
    step(1'b0, 64'd0, 1'b0, 1'b1, rci);
    n = 0;
    while (frame_open() && n < LIMIT) begin
      step(($urandom_range(0, 3) != 0), {$urandom(), $urandom()},
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)));
      n++;
    end
    bound("t6_frame", n);
    chk("t6_count", 64'(seen.size()), 64'(RW * WPR * (int'(rci) + 1)));

    // Reset in the middle of a frame, then a fresh 8-word frame.
    start_conv = 1'b0;
    do_reset();
    seen.delete();
    step(1'b0, 64'd0, 1'b0, 1'b1, 2'd2);
    word = 64'h50;
    n = 0;
    while (seen.size() < 5 && n < LIMIT) begin
      p0 = pushes;
      step(1'b1, word, (m_q.size() > 0), 1'b0, 2'd0);
      if (pushes != p0) word++;
      n++;
    end
    bound("t7_prefix", n);
    do_reset();
    seen.delete();
    done_seen = 0;
    step(1'b0, 64'd0, 1'b0, 1'b1, 2'd0);
    word = 64'h100;
    n = 0;
    while (frame_open() && n < LIMIT) begin
      p0 = pushes;
      step(1'b1, word, (m_q.size() > 0), 1'b0, 2'd0);
      if (pushes != p0) word++;
      n++;
    end
    bound("t7_frame", n);
    chk("t7_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("t7_word", seen[i], 64'h100 + 64'(i));
    chk("t7_done_pulses", 64'(done_seen), 64'd1);

    repeat (2) step(1'b0, 64'd0, 1'b0, 1'b0, 2'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_feeder.md
Name: ifmap_feeder

Overview:
- Responder side of the convolution controller's input-feature read interface (read_I / Idata).
- Accepts 64-bit feature words from a host valid/ready stream and buffers them in a small FIFO.
- Returns one registered word per read_I request, one cycle later.
- Frame length is fixed by cfg_ci at start_conv; raises frame_done once the last word of the frame is delivered.

Parameters:
- DATA_W, 64, word width of host_data and Idata
- ROWS, 64, feature rows per channel
- WORDS_PER_ROW, 256, 64-bit words per feature row (16384 bits / 64)
- FIFO_DEPTH, 16, buffer entries, power of two
- CNT_W, 17, frame word counter width; must hold ROWS*WORDS_PER_ROW*4

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_conv  input  1  one-cycle pulse; latches cfg_ci and opens a frame
- cfg_ci  input  2  input-channel count minus one (0..3 -> 1..4 channels)
- host_valid  input  1  host word valid
- host_data  input  DATA_W  host feature word
- host_ready  output  1  feeder accepts host word this cycle
- read_I  input  1  controller word request, one word per asserted cycle
- Idata  output  DATA_W  returned feature word
- i_valid  output  1  Idata valid, one-cycle pulse
- frame_done  output  1  one-cycle pulse after the last frame word is returned
- underflow  output  1  sticky error flag
- busy  output  1  high while in STREAM

Behaviour:
- Reset (async, rst=1):
  - FIFO flushed; in_cnt and out_cnt cleared; state IDLE.
  - Outputs: Idata=0, i_valid=0, host_ready=0, frame_done=0, underflow=0, busy=0.
  - Reset asserted mid-frame abandons the frame; there is no resume.
- Frame length: total = ROWS*WORDS_PER_ROW*(cfg_ci+1), computed at CNT_W bits and latched on start_conv.
- State machine:
  - IDLE: start_conv=1 -> STREAM; clear in_cnt and out_cnt; latch total.
  - STREAM: out_cnt reaches total on a pop -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE the following cycle.
- start_conv in STREAM or DONE is ignored; no relatch, no count clear.
- Host side:
  - host_ready = (state==STREAM) && !fifo_full && (in_cnt < total). This is combinational from registered state only; it never depends on host_valid.
  - Push when host_valid && host_ready; in_cnt increments.
  - Words beyond total are never accepted, because host_ready is low.
- Read side:
  - A pop occurs when read_I=1 in STREAM with the FIFO non-empty.
  - On a pop at cycle n: at n+1, Idata = the popped word and i_valid=1; out_cnt increments at n+1.
  - Idata holds its last value when i_valid=0.
- Underflow, all set underflow=1 (sticky until rst):
  - read_I=1 with the FIFO empty in STREAM.
  - read_I=1 in IDLE or DONE.
  - In these cases there is no pop, i_valid stays 0, and the counters are unchanged.
- Simultaneous push and pop:
  - Both are performed; occupancy is unchanged.
  - When full, push is blocked because host_ready=0.
  - When empty, there is no bypass: the pop fails and raises underflow.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
- frame_done asserts the cycle after the i_valid pulse of the last word.
- busy = (state==STREAM).

Decomposition:
- Shared package feeder_pkg holds:
  - the state enum {IDLE, STREAM, DONE};
  - the constants DATA_W, ROWS, WORDS_PER_ROW;
  - a function frame_words(cfg_ci) returning CNT_W bits.
- One sub-module, sync_fifo (params DATA_W, FIFO_DEPTH):
  - ports push, pop, wdata, rdata, full, empty;
  - registered rdata;
  - same clk and async rst.
- The feeder instantiates sync_fifo plus the FSM and counters.

Test Plan (bench overrides ROWS=2, WORDS_PER_ROW=4):
- Reset then idle: host_valid=1 with no start_conv -> host_ready=0 and all outputs 0 throughout.
- start_conv with cfg_ci=1 (total=16):
  - Stimulus: host pushes words 0x0..0xF; controller issues read_I whenever the FIFO is non-empty.
  - Required response: Idata sequence 0x0..0xF in order, each one cycle after its read_I; frame_done pulses once, one cycle after the 0xF i_valid pulse; state returns to IDLE.
- FIFO_DEPTH=16 with no reads, 20 host words offered -> exactly 16 accepted and host_ready low from the cycle after the 16th push; then 16 reads return words 0..15 in order.
- read_I with the FIFO empty in STREAM -> i_valid=0 and underflow=1, held until rst; out_cnt unchanged and the frame still completes.
- Simultaneous push and pop every cycle at occupancy 1 -> occupancy stays 1 and order is preserved across pointer wrap (at least 40 words with cfg_ci=3, total=32, over two frames).
- rst asserted at word 5 of a frame -> all outputs 0 immediately; the next start_conv with cfg_ci=0 (total=8) delivers exactly 8 fresh words.
